// File: rtl/ecc_pkg.sv
// ecc_pkg - shared definitions for the ECC scalar-multiply controller.
//   WIDTH        : coordinate / scalar width (256-bit field)
//   IDX_W        : width of the scalar bit index
//   point_t      : affine point {x, y}
//   ctrl_state_e : controller FSM states
package ecc_pkg;

  localparam int WIDTH = 256;
  localparam int IDX_W = $clog2(WIDTH);

  typedef struct packed {
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
  } point_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BIT,
    ST_DBL_REQ,
    ST_DBL_WAIT,
    ST_ADD_REQ,
    ST_ADD_WAIT,
    ST_DONE
  } ctrl_state_e;

endpackage

// File: rtl/ecc_op_issue.sv
// ecc_op_issue - request formatter for the shared external point-add unit.
//   clk, rst_n            : clock, synchronous active-low reset
//   req_dbl_i, req_add_i  : one-cycle request from the FSM (acc+acc / acc+G)
//   use_g_i               : accumulator is at infinity, substitute G for it
//   acc_x_i/acc_y_i       : accumulator point
//   g_x_i/g_y_i           : base point
//   add_in_valid_o, add_p*_o, add_q*_o : request to the add unit (operands 0 when idle)
//   add_out_valid_i, add_r*_i          : add unit result
//   res_valid_o, res_x_o/res_y_o       : result strobe back to the FSM
module ecc_op_issue
  import ecc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_dbl_i,
  input  logic             req_add_i,
  input  logic             use_g_i,
  input  logic [WIDTH-1:0] acc_x_i,
  input  logic [WIDTH-1:0] acc_y_i,
  input  logic [WIDTH-1:0] g_x_i,
  input  logic [WIDTH-1:0] g_y_i,
  output logic             add_in_valid_o,
  output logic [WIDTH-1:0] add_px_o,
  output logic [WIDTH-1:0] add_py_o,
  output logic [WIDTH-1:0] add_qx_o,
  output logic [WIDTH-1:0] add_qy_o,
  input  logic             add_out_valid_i,
  input  logic [WIDTH-1:0] add_rx_i,
  input  logic [WIDTH-1:0] add_ry_i,
  output logic             res_valid_o,
  output logic [WIDTH-1:0] res_x_o,
  output logic [WIDTH-1:0] res_y_o
);

  point_t p_op, q_op;
  logic   pending_q;

  // NOTE: every signal assigned in always_comb gets a default first, otherwise
  // a path that skips the assignment infers a latch.
  always_comb begin
    p_op = use_g_i ? point_t'{x: g_x_i, y: g_y_i} : point_t'{x: acc_x_i, y: acc_y_i};
    q_op = req_add_i ? point_t'{x: g_x_i, y: g_y_i} : p_op;

    add_in_valid_o = req_dbl_i | req_add_i;
    add_px_o       = '0;
    add_py_o       = '0;
    add_qx_o       = '0;
    add_qy_o       = '0;
    if (add_in_valid_o) begin
      add_px_o = p_op.x;
      add_py_o = p_op.y;
      add_qx_o = q_op.x;
      add_qy_o = q_op.y;
    end
  end

  // Tracks the single outstanding request; a strobe with nothing pending
  // (e.g. a late answer to a request aborted by reset) is dropped here.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
    end else if (add_in_valid_o) begin
      pending_q <= 1'b1;
    end else if (add_out_valid_i) begin
      pending_q <= 1'b0;
    end
  end

  assign res_valid_o = pending_q & add_out_valid_i;
  assign res_x_o     = add_rx_i;
  assign res_y_o     = add_ry_i;

endmodule

// File: rtl/ecc_scalar_mul_ctrl.sv
// ecc_scalar_mul_ctrl - R = k*G by left-to-right double-and-add, sharing one
// external point-add unit. Tracks the point at infinity, which the add unit
// cannot represent.
//   clk, rst_n                  : clock, synchronous active-low reset
//   start, k, Gx, Gy            : command; k and G latched when start accepted in IDLE
//   busy, done                  : busy from the cycle after accept; done one-cycle pulse
//   Rx, Ry, r_inf               : result, held until the next completion
//   add_in_valid, add_P*/add_Q* : request to the add unit (P==Q means doubling)
//   add_out_valid, add_Rx/add_Ry: add unit result
// Build option: define ECC_CONST_TIME_EN to issue one double and one add for
// every scalar bit, discarding results that do not apply.
module ecc_scalar_mul_ctrl
  import ecc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] Gx,
  input  logic [WIDTH-1:0] Gy,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Rx,
  output logic [WIDTH-1:0] Ry,
  output logic             r_inf,
  output logic             add_in_valid,
  output logic [WIDTH-1:0] add_Px,
  output logic [WIDTH-1:0] add_Py,
  output logic [WIDTH-1:0] add_Qx,
  output logic [WIDTH-1:0] add_Qy,
  input  logic             add_out_valid,
  input  logic [WIDTH-1:0] add_Rx,
  input  logic [WIDTH-1:0] add_Ry
);

  ctrl_state_e      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] k_q, k_d;
  point_t           g_q, g_d, acc_q, acc_d, r_q, r_d;
  logic             acc_inf_q, acc_inf_d;
  logic             busy_q, busy_d, done_q, done_d, r_inf_q, r_inf_d;
  logic             req_dbl, req_add, advance, bit_b;
  logic             res_valid;
  logic [WIDTH-1:0] res_x, res_y;

  assign bit_b = k_q[idx_q];

  ecc_op_issue u_op_issue (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_dbl_i       (req_dbl),
    .req_add_i       (req_add),
    .use_g_i         (acc_inf_q),
    .acc_x_i         (acc_q.x),
    .acc_y_i         (acc_q.y),
    .g_x_i           (g_q.x),
    .g_y_i           (g_q.y),
    .add_in_valid_o  (add_in_valid),
    .add_px_o        (add_Px),
    .add_py_o        (add_Py),
    .add_qx_o        (add_Qx),
    .add_qy_o        (add_Qy),
    .add_out_valid_i (add_out_valid),
    .add_rx_i        (add_Rx),
    .add_ry_i        (add_Ry),
    .res_valid_o     (res_valid),
    .res_x_o         (res_x),
    .res_y_o         (res_y)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    k_d       = k_q;
    g_d       = g_q;
    acc_d     = acc_q;
    acc_inf_d = acc_inf_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    r_d       = r_q;
    r_inf_d   = r_inf_q;
    req_dbl   = 1'b0;
    req_add   = 1'b0;
    advance   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          k_d       = k;
          g_d       = '{x: Gx, y: Gy};
          idx_d     = '1;
          acc_inf_d = 1'b1;
          busy_d    = 1'b1;
          state_d   = ST_BIT;
        end
      end
      ST_BIT: begin
`ifdef ECC_CONST_TIME_EN
        state_d = ST_DBL_REQ;
`else
        if (!acc_inf_q) begin
          state_d = ST_DBL_REQ;
        end else begin
          // First set bit: load G directly, no add unit needed.
          if (bit_b) begin
            acc_d     = g_q;
            acc_inf_d = 1'b0;
          end
          advance = 1'b1;
        end
`endif
      end
      ST_DBL_REQ: begin
        req_dbl = 1'b1;
        state_d = ST_DBL_WAIT;
      end
      ST_DBL_WAIT: begin
        if (res_valid) begin
          // Doubling infinity stays infinity; only reachable in const-time mode.
          if (!acc_inf_q) acc_d = '{x: res_x, y: res_y};
`ifdef ECC_CONST_TIME_EN
          state_d = ST_ADD_REQ;
`else
          if (bit_b) state_d = ST_ADD_REQ;
          else       advance = 1'b1;
`endif
        end
      end
      ST_ADD_REQ: begin
        req_add = 1'b1;
        state_d = ST_ADD_WAIT;
      end
      ST_ADD_WAIT: begin
        if (res_valid) begin
          // In const-time mode the add result is dummy work when b=0, and
          // infinity+G is G (the unit computed G+G instead).
          if (bit_b) begin
            if (acc_inf_q) begin
              acc_d     = g_q;
              acc_inf_d = 1'b0;
            end else begin
              acc_d = '{x: res_x, y: res_y};
            end
          end
          advance = 1'b1;
        end
      end
      ST_DONE: begin
        r_d     = acc_inf_q ? '0 : acc_q;
        r_inf_d = acc_inf_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (advance) begin
      if (idx_q == '0) begin
        state_d = ST_DONE;
      end else begin
        idx_d   = idx_q - 1'b1;
        state_d = ST_BIT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      acc_inf_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      r_q       <= '0;
      r_inf_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_inf_q <= acc_inf_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      r_q       <= r_d;
      r_inf_q   <= r_inf_d;
    end
  end

  // NOTE: wide datapath registers carry no reset; they are always written
  // before being read, and the control state above decides when that is.
  always_ff @(posedge clk) begin
    k_q   <= k_d;
    g_q   <= g_d;
    acc_q <= acc_d;
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign Rx    = r_q.x;
  assign Ry    = r_q.y;
  assign r_inf = r_inf_q;

endmodule

// File: tb/tb_ecc_scalar_mul_ctrl.sv
// tb_ecc_scalar_mul_ctrl - self-checking bench for ecc_scalar_mul_ctrl.
// Contains a behavioural add unit (fixed latency, tagged results) and a
// scalar-multiply reference model written directly from the algorithm.
// Honours ECC_CONST_TIME_EN when the RTL is built with it.
module tb_ecc_scalar_mul_ctrl;
  import ecc_pkg::*;

  localparam int LAT   = 5;
  localparam int LIMIT = 20000;
`ifdef ECC_CONST_TIME_EN
  localparam bit CONST_TIME = 1'b1;
`else
  localparam bit CONST_TIME = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n, start;
  logic [WIDTH-1:0] k, Gx, Gy;
  logic             busy, done, r_inf;
  logic [WIDTH-1:0] Rx, Ry;
  logic             add_in_valid, add_out_valid;
  logic [WIDTH-1:0] add_Px, add_Py, add_Qx, add_Qy, add_Rx, add_Ry;

  always #5 clk = ~clk;

  ecc_scalar_mul_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .k             (k),
    .Gx            (Gx),
    .Gy            (Gy),
    .busy          (busy),
    .done          (done),
    .Rx            (Rx),
    .Ry            (Ry),
    .r_inf         (r_inf),
    .add_in_valid  (add_in_valid),
    .add_Px        (add_Px),
    .add_Py        (add_Py),
    .add_Qx        (add_Qx),
    .add_Qy        (add_Qy),
    .add_out_valid (add_out_valid),
    .add_Rx        (add_Rx),
    .add_Ry        (add_Ry)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Deterministic, order-sensitive stand-in for point addition.
  function automatic point_t add_model(input point_t p, input point_t q);
    point_t r;
    r.x = p.x * 5 + q.x * 3 + 1;
    r.y = p.y * 7 + q.y + 2;
    return r;
  endfunction

  // ---------------- behavioural add unit + request monitor ----------------
  int     cnt = 0;
  int     pulse_cnt = 0, op_err = 0, ovl_err = 0;
  point_t pend;
  point_t exp_p[$], exp_q[$];

  always @(negedge clk) begin
    point_t p, q, ep, eq;
    add_out_valid = 1'b0;
    add_Rx        = '0;
    add_Ry        = '0;
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        add_out_valid = 1'b1;
        add_Rx        = pend.x;
        add_Ry        = pend.y;
      end
    end
    if (add_in_valid === 1'b1) begin
      pulse_cnt++;
      if (cnt != 0) ovl_err++;
      p = '{x: add_Px, y: add_Py};
      q = '{x: add_Qx, y: add_Qy};
      if (exp_p.size() == 0) begin
        op_err++;
      end else begin
        ep = exp_p.pop_front();
        eq = exp_q.pop_front();
        if (p !== ep || q !== eq) op_err++;
      end
      pend = add_model(p, q);
      cnt  = LAT;
    end else if ((add_Px | add_Py | add_Qx | add_Qy) !== '0) begin
      op_err++;
    end
  end

  // ---------------- reference model ----------------
  // Walks k MSB-first: double when the accumulator is finite, then add G on a
  // one bit (the first one bit simply loads G). Queues every request the
  // controller is expected to make and returns the request count.
  task automatic ref_model(input logic [WIDTH-1:0] kk, input point_t g,
                           output point_t r, output logic inf, output int ops);
    point_t acc, p, d;
    logic   ai;
    acc = '0;
    ai  = 1'b1;
    ops = 0;
    exp_p.delete();
    exp_q.delete();
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (CONST_TIME) begin
        p = ai ? g : acc;
        exp_p.push_back(p); exp_q.push_back(p); ops++;
        d = add_model(p, p);
        if (!ai) acc = d;
        p = ai ? g : acc;
        exp_p.push_back(p); exp_q.push_back(g); ops++;
        d = add_model(p, g);
        if (kk[i]) begin
          if (ai) begin acc = g; ai = 1'b0; end
          else acc = d;
        end
      end else begin
        if (!ai) begin
          exp_p.push_back(acc); exp_q.push_back(acc); ops++;
          acc = add_model(acc, acc);
        end
        if (kk[i]) begin
          if (ai) begin
            acc = g;
            ai  = 1'b0;
          end else begin
            exp_p.push_back(acc); exp_q.push_back(g); ops++;
            acc = add_model(acc, g);
          end
        end
      end
    end
    r   = ai ? '0 : acc;
    inf = ai;
  endtask

  // ---------------- one scalar multiplication ----------------
  task automatic run_op(input string tag, input logic [WIDTH-1:0] kk, input point_t g,
                        input bit mid_start, output point_t r, output logic inf,
                        output int lat);
    @(negedge clk);
    k = kk; Gx = g.x; Gy = g.y; start = 1'b1;
    pulse_cnt = 0; op_err = 0; ovl_err = 0;
    @(negedge clk);
    start = 1'b0;
    k = ~kk; Gx = ~g.x; Gy = ~g.y;  // inputs must already be latched
    lat = 0;
    check({tag, " busy_after_accept"}, busy, 1);
    while (done !== 1'b1 && lat < LIMIT) begin
      @(negedge clk);
      lat++;
      start = mid_start && (lat == 20);
    end
    start = 1'b0;
    check({tag, " timeout"}, (done !== 1'b1), 0);
    r   = '{x: Rx, y: Ry};
    inf = r_inf;
    check({tag, " busy_at_done"}, busy, 0);
    @(negedge clk);
    check({tag, " done_one_cycle"}, done, 0);
    check({tag, " op_operands"}, op_err, 0);
    check({tag, " one_outstanding"}, ovl_err, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " Rx"}, Rx, 0);
    check({tag, " Ry"}, Ry, 0);
    check({tag, " r_inf"}, r_inf, 0);
    check({tag, " add_in_valid"}, add_in_valid, 0);
    check({tag, " add_ops"}, add_Px | add_Py | add_Qx | add_Qy, 0);
  endtask

  typedef struct {
    logic [WIDTH-1:0] k;
    bit               mid_start;
    point_t           r;
    logic             inf;
    int               pulses;
    int               lat;
  } vec_t;

  initial begin
    vec_t             vecs[4];
    point_t           g, g2, g3, r, dummy_r;
    logic             inf, dummy_inf;
    logic [WIDTH-1:0] kk;
    int               lat, ops, waited;
    bit               seen;

    rst_n = 1'b0; start = 1'b0; k = '0; Gx = '0; Gy = '0;
    add_out_valid = 1'b0; add_Rx = '0; add_Ry = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;

    g  = '{x: 256'h1, y: 256'h2};
    g2 = add_model(g, g);
    g3 = add_model(g2, g);
    vecs[0] = '{k: 256'd0, mid_start: 1'b0, r: '0, inf: 1'b1,
                pulses: CONST_TIME ? 512 : 0, lat: CONST_TIME ? 3329 : 257};
    vecs[1] = '{k: 256'd1, mid_start: 1'b0, r: g, inf: 1'b0,
                pulses: CONST_TIME ? 512 : 0, lat: CONST_TIME ? 3329 : 257};
    vecs[2] = '{k: 256'd2, mid_start: 1'b0, r: g2, inf: 1'b0,
                pulses: CONST_TIME ? 512 : 1, lat: CONST_TIME ? 3329 : 263};
    vecs[3] = '{k: 256'd3, mid_start: 1'b1, r: g3, inf: 1'b0,
                pulses: CONST_TIME ? 512 : 2, lat: CONST_TIME ? 3329 : 269};

    for (int i = 0; i < 4; i++) begin
      ref_model(vecs[i].k, g, dummy_r, dummy_inf, ops);  // loads expected requests
      run_op($sformatf("vec%0d", i), vecs[i].k, g, vecs[i].mid_start, r, inf, lat);
      check($sformatf("vec%0d Rx", i), r.x, vecs[i].r.x);
      check($sformatf("vec%0d Ry", i), r.y, vecs[i].r.y);
      check($sformatf("vec%0d r_inf", i), inf, vecs[i].inf);
      check($sformatf("vec%0d pulses", i), pulse_cnt, vecs[i].pulses);
      check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
    end

    // Random scalars and base points against the reference model.
    for (int n = 0; n < 4; n++) begin
      point_t rg, er;
      logic   einf;
      kk = '0;
      for (int w = 0; w < WIDTH / 32; w++) kk = {kk[WIDTH-33:0], 32'($urandom())};
      if (n == 3) kk = kk & {{(WIDTH-16){1'b0}}, 16'hFFFF};  // short scalar
      rg.x = {224'h0, 32'($urandom())};
      rg.y = {224'h0, 32'($urandom())};
      ref_model(kk, rg, er, einf, ops);
      run_op($sformatf("rnd%0d", n), kk, rg, 1'b0, r, inf, lat);
      check($sformatf("rnd%0d Rx", n), r.x, er.x);
      check($sformatf("rnd%0d Ry", n), r.y, er.y);
      check($sformatf("rnd%0d r_inf", n), inf, einf);
      check($sformatf("rnd%0d pulses", n), pulse_cnt, ops);
      check($sformatf("rnd%0d latency", n), lat, WIDTH + ops * (LAT + 1) + 1);
    end

    // Reset while a doubling is outstanding; its late result must be ignored.
    ref_model(256'hFF, g, dummy_r, dummy_inf, ops);
    @(negedge clk);
    k = 256'hFF; Gx = g.x; Gy = g.y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waited = 0;
    while (add_in_valid !== 1'b1 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check("rst_mid first_request_seen", add_in_valid, 1);
    repeat (2) @(negedge clk);  // now inside the wait for the result
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_mid");
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (add_in_valid === 1'b1 || busy === 1'b1 || done === 1'b1) seen = 1'b1;
    end
    check("rst_mid quiet_after_late_result", seen, 0);
    ref_model(256'd1, g, dummy_r, dummy_inf, ops);
    run_op("after_rst", 256'd1, g, 1'b0, r, inf, lat);
    check("after_rst Rx", r.x, g.x);
    check("after_rst Ry", r.y, g.y);
    check("after_rst r_inf", inf, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ecc_scalar_mul_ctrl.md
# ecc_scalar_mul_ctrl

Sequencer computing R = k·G over the 256-bit curve field by left-to-right double-and-add, time-sharing one external point-add unit (P+Q, with P==Q meaning doubling) through its in_valid/out_valid handshake. Sits between the top-level command interface and the point-add datapath. Holds the accumulator and the point-at-infinity state, which the add unit does not handle.

## Interface
- WIDTH, 256, coordinate and scalar width
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- k  in  WIDTH  scalar, latched on accepted start
- Gx, Gy  in  WIDTH  base point, latched on accepted start
- busy  out  1  high from the cycle after accept until DONE
- done  out  1  one-cycle pulse; result valid
- Rx, Ry  out  WIDTH  result, held until next accepted start
- r_inf  out  1  result is point at infinity (Rx=Ry=0)
- add_in_valid  out  1  one-cycle request to add unit
- add_Px, add_Py, add_Qx, add_Qy  out  WIDTH  operands, valid while add_in_valid=1, 0 otherwise
- add_out_valid  in  1  add unit result strobe
- add_Rx, add_Ry  in  WIDTH  add unit result, captured when add_out_valid=1

## Operation
- States: IDLE, BIT, DBL_REQ, DBL_WAIT, ADD_REQ, ADD_WAIT, DONE.
- IDLE: on start, latch k, G; idx=255; acc_inf=1; go BIT. start in any other state ignored.
- BIT (bit b=k[idx]): if acc_inf=0 → DBL_REQ. Else if b=1 → acc=G, acc_inf=0, advance. Else advance.
- DBL_REQ: issue acc+acc → DBL_WAIT. On add_out_valid: acc=result → (b=1 ? ADD_REQ : advance).
- ADD_REQ: issue acc+G → ADD_WAIT. On add_out_valid: acc=result → advance.
- Advance: idx==0 → DONE; else idx−1, → BIT.
- DONE: Rx,Ry=acc (0 if acc_inf), r_inf=acc_inf, done=1 one cycle → IDLE.
- add_out_valid outside *_WAIT states ignored; exactly one request outstanding at any time.
- k=0 → r_inf=1, Rx=Ry=0, no add requests.

## Timing
- Reset: busy=0, done=0, Rx=Ry=0, r_inf=0, add_in_valid=0, all add operands 0, state IDLE.
- Reset mid-operation: abort immediately, no done; a late add_out_valid after reset is ignored.
- Each BIT visit 1 cycle; each op = 1 REQ cycle + wait cycles up to and including add_out_valid cycle.
- Total latency from start-sampling edge to done: 256 + Σ(op cycles) + 1; k=0 → done 257 cycles after start sampled (non-const-time).
- busy falls the same edge done rises; new start accepted the cycle after done.
- Add unit latency is arbitrary (≥1); no timeout.

## Configuration
- ECC_CONST_TIME_EN defined: every bit issues exactly one double then one add (512 requests per scalar regardless of k). Operands use G in place of acc while acc_inf=1; results discarded when not applicable (double while acc_inf, add when b=0); acc/acc_inf update exactly as without the macro.
- Undefined: only needed operations issued, per Operation.

## Structure
- Shared package ecc_pkg: WIDTH, point struct {x,y}, controller state enum.
- One natural sub-module: ecc_op_issue — formats operands, pulses add_in_valid, waits for add_out_valid, returns result strobe to the FSM.

## Test plan
- Behavioural add model, fixed latency 5, returns deterministic tagged results; G=(0x…01,0x…02).
- k=0 → done at cycle 257, r_inf=1, Rx=Ry=0, zero add_in_valid pulses.
- k=1 → Rx,Ry=G, r_inf=0, zero pulses; k=2 → one pulse with P=Q=G, R=model(G,G).
- k=3 → two pulses: (G,G) then (2G,G); R matches model chain; start pulsed mid-run ignored.
- Reset asserted during DBL_WAIT of k=0xFF → outputs reset values, late add_out_valid ignored, next start with k=1 returns G.
- With ECC_CONST_TIME_EN, k=1 → exactly 512 pulses, R=G, r_inf=0; k=0 → 512 pulses, r_inf=1.
